// File: rtl/dro_pkg.sv
// Shared definitions for the DRO clock/data transmitter and its receiver peer.
package dro_pkg;

  localparam int unsigned DRO_MAX_BITS = 32;
  localparam int unsigned DRO_DEF_HZ   = 48_000_000;

  // Command codes on the shared command bus
  localparam logic [7:0] DRO_CMD_CONFIG_TX = 8'h30;
  localparam logic [7:0] DRO_CMD_SEND      = 8'h31;

  typedef enum logic {
    C_IDLE,
    C_ARG2
  } cmd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LO   = 2'd1,
    TX_HI   = 2'd2,
    TX_GAP  = 2'd3
  } tx_state_t;

  // Timer width able to hold one second's worth of clock cycles
  function automatic int unsigned dro_timer_bits(input int unsigned hz);
    return $clog2(hz + 1);
  endfunction

  function automatic logic [5:0] dro_clamp_nbits(input logic [5:0] n);
    return (n > 6'(DRO_MAX_BITS)) ? 6'(DRO_MAX_BITS) : n;
  endfunction

endpackage

// File: rtl/dro_tx_shifter.sv
// Serial frame engine: shift register, bit counter, half/gap countdown, TX FSM.
module dro_tx_shifter
  import dro_pkg::*;
#(
  parameter int unsigned TIMER_BITS = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [31:0]           i_value,
  input  logic [5:0]            i_nbits,
  input  logic [TIMER_BITS-1:0] i_half,
  input  logic [TIMER_BITS-1:0] i_gap,
  output logic                  o_idle,
  output logic                  o_dro_clk,
  output logic                  o_dro_do,
  output logic [5:0]            o_bitcnt,
  output logic [1:0]            o_state
);

  tx_state_t             r_state, w_next;
  logic [31:0]           r_sr;
  logic [5:0]            r_bitcnt;
  logic [TIMER_BITS-1:0] r_cnt, r_half, r_gap;
  logic                  r_dro_clk, r_dro_do;
  logic                  w_expire;
  logic [31:0]           w_aligned;

  assign w_expire  = (r_cnt == TIMER_BITS'(1));
  // Left-align so bit nbits-1 of the value lands on bit 31
  assign w_aligned = i_value << (6'd32 - i_nbits);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TX_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE: if (i_start)  w_next = TX_LO;
      TX_LO:   if (w_expire) w_next = TX_HI;
      TX_HI:   if (w_expire) w_next = (r_bitcnt != 6'd0) ? TX_LO : TX_GAP;
      TX_GAP:  if (w_expire) w_next = TX_IDLE;
      default: w_next = TX_IDLE;
    endcase
  end

  // Datapath: timing snapshot, shift register, bit counter and pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      r_half    <= '0;
      r_gap     <= '0;
      r_dro_clk <= 1'b1;
      r_dro_do  <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: if (i_start) begin
          // Timing is snapshotted here so a CONFIG mid-frame cannot disturb it
          r_sr      <= w_aligned;
          r_bitcnt  <= i_nbits;
          r_cnt     <= i_half;
          r_half    <= i_half;
          r_gap     <= i_gap;
          r_dro_clk <= 1'b0;
          r_dro_do  <= w_aligned[31];
        end
        TX_LO: if (w_expire) begin
          r_dro_clk <= 1'b1;
          r_bitcnt  <= r_bitcnt - 6'd1;
          r_cnt     <= r_half;
        end else begin
          r_cnt <= r_cnt - TIMER_BITS'(1);
        end
        TX_HI: if (w_expire) begin
          if (r_bitcnt != 6'd0) begin
            r_dro_clk <= 1'b0;
            r_sr      <= r_sr << 1;
            r_dro_do  <= r_sr[30];
            r_cnt     <= r_half;
          end else begin
            r_cnt <= r_gap;
          end
        end else begin
          r_cnt <= r_cnt - TIMER_BITS'(1);
        end
        TX_GAP: if (w_expire) begin
          r_dro_do <= 1'b0;
        end else begin
          r_cnt <= r_cnt - TIMER_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_idle    = (r_state == TX_IDLE);
    o_dro_clk = r_dro_clk;
    o_dro_do  = r_dro_do;
    o_bitcnt  = r_bitcnt;
    o_state   = r_state;
  end

endmodule

// File: rtl/dro_tx.sv
// DRO transmitter: command decoder, timing configuration and one-deep pending slot.
module dro_tx
  import dro_pkg::*;
#(
  parameter int unsigned         HZ                = DRO_DEF_HZ,
  parameter int unsigned         CMD_BITS          = 8,
  parameter logic [CMD_BITS-1:0] CMD_CONFIG_DRO_TX = CMD_BITS'(DRO_CMD_CONFIG_TX),
  parameter logic [CMD_BITS-1:0] CMD_DRO_SEND      = CMD_BITS'(DRO_CMD_SEND),
  parameter int unsigned         DEF_HALF          = HZ / 100000,
  parameter int unsigned         DEF_GAP           = HZ / 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         arg_data,
  output logic                arg_advance,
  input  logic [CMD_BITS-1:0] cmd,
  input  logic                cmd_ready,
  output logic                cmd_done,
  output logic                dro_clk,
  output logic                dro_do,
  output logic                busy,
  output logic [15:0]         debug
);

  localparam int unsigned TIMER_BITS = dro_timer_bits(HZ);

  cmd_state_t            r_cmd_state, w_cmd_next;
  logic [TIMER_BITS-1:0] r_half, r_gap, w_timer_arg;
  logic [31:0]           r_arg0, r_pend_data;
  logic [5:0]            r_pend_nbits, w_nbits, w_bitcnt;
  logic                  r_pend_valid, r_is_cfg;
  logic                  w_is_cfg, w_is_send, w_tx_idle, w_drain, w_slot_free;
  logic [1:0]            w_tx_state;

  assign w_is_cfg    = (cmd == CMD_CONFIG_DRO_TX);
  assign w_is_send   = (cmd == CMD_DRO_SEND);
  assign w_drain     = r_pend_valid & w_tx_idle;
  // A full slot still counts as free when the transmitter takes it this cycle
  assign w_slot_free = ~r_pend_valid | w_tx_idle;
  assign w_nbits     = dro_clamp_nbits(arg_data[5:0]);

  // Timing argument: saturate to the register range, zero becomes one
  always_comb begin
    w_timer_arg = (|arg_data[31:TIMER_BITS]) ? '1 : arg_data[TIMER_BITS-1:0];
    if (w_timer_arg == '0) w_timer_arg = TIMER_BITS'(1);
  end

  // Command state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cmd_state <= C_IDLE;
    else        r_cmd_state <= w_cmd_next;
  end

  // Command next-state logic
  always_comb begin
    w_cmd_next = r_cmd_state;
    case (r_cmd_state)
      C_IDLE:  if (cmd_ready && (w_is_cfg || (w_is_send && w_slot_free))) w_cmd_next = C_ARG2;
      C_ARG2:  w_cmd_next = C_IDLE;
      default: w_cmd_next = C_IDLE;
    endcase
  end

  // Command handshake outputs
  always_comb begin
    arg_advance = 1'b0;
    cmd_done    = 1'b0;
    case (r_cmd_state)
      C_IDLE: if (cmd_ready) begin
        if (w_is_cfg || w_is_send) arg_advance = w_is_cfg | w_slot_free;
        else                       cmd_done    = 1'b1;
      end
      C_ARG2: begin
        arg_advance = 1'b1;
        cmd_done    = 1'b1;
      end
      default: ;
    endcase
  end

  // Configuration registers and pending slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half       <= TIMER_BITS'(DEF_HALF);
      r_gap        <= TIMER_BITS'(DEF_GAP);
      r_arg0       <= '0;
      r_is_cfg     <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_pend_nbits <= '0;
    end else begin
      if (r_cmd_state == C_IDLE && arg_advance) begin
        r_is_cfg <= w_is_cfg;
        r_arg0   <= arg_data;
        if (w_is_cfg) r_half <= w_timer_arg;
      end
      if (w_drain) r_pend_valid <= 1'b0;
      if (r_cmd_state == C_ARG2) begin
        if (r_is_cfg) begin
          r_gap <= w_timer_arg;
        end else if (w_nbits != 6'd0) begin
          r_pend_valid <= 1'b1;
          r_pend_data  <= r_arg0;
          r_pend_nbits <= w_nbits;
        end
      end
    end
  end

  dro_tx_shifter #(
    .TIMER_BITS(TIMER_BITS)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_drain),
    .i_value  (r_pend_data),
    .i_nbits  (r_pend_nbits),
    .i_half   (r_half),
    .i_gap    (r_gap),
    .o_idle   (w_tx_idle),
    .o_dro_clk(dro_clk),
    .o_dro_do (dro_do),
    .o_bitcnt (w_bitcnt),
    .o_state  (w_tx_state)
  );

  assign busy  = ~w_tx_idle | r_pend_valid;
  assign debug = {7'b0, r_pend_valid, w_bitcnt, w_tx_state};

endmodule

// File: tb/tb_dro_tx.sv
// Bench for dro_tx: per-cycle waveform model plus a behavioural DRO receiver.
module tb_dro_tx;
  import dro_pkg::*;

  localparam int unsigned HZ = 1_000_000;
  localparam int DEF_H = 10;
  localparam int DEF_G = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] arg_data = '0;
  logic        arg_advance;
  logic [7:0]  cmd = '0;
  logic        cmd_ready = 1'b0;
  logic        cmd_done, dro_clk, dro_do, busy;
  logic [15:0] debug;

  dro_tx #(.HZ(HZ)) dut (
    .clk(clk), .rst_n(rst_n), .arg_data(arg_data), .arg_advance(arg_advance),
    .cmd(cmd), .cmd_ready(cmd_ready), .cmd_done(cmd_done), .dro_clk(dro_clk),
    .dro_do(dro_do), .busy(busy), .debug(debug)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase, m_half, m_gap, m_slot_n, m_s, m_n, m_h, m_g;
  bit          m_cfg, m_slot_v, m_act;
  logic [31:0] m_arg0, m_slot_val, m_val;

  function automatic int tval(input logic [31:0] a);
    return (a == 0) ? 1 : int'(a);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cfg = 0; m_half = DEF_H; m_gap = DEF_G;
    m_slot_v = 0; m_act = 0;
  endtask

  task automatic model_check();
    logic e_clk, e_do, e_adv, e_done;
    int k, l;
    e_clk = 1; e_do = 0; e_adv = 0; e_done = 0;
    if (m_act) begin
      k = cyc - m_s;
      l = 2 * m_h * m_n;
      if (k < l) begin
        e_clk = ((k % (2 * m_h)) >= m_h);
        e_do  = m_val[m_n - 1 - k / (2 * m_h)];
      end else begin
        e_do = m_val[0];
      end
    end
    if (m_phase == 1) begin
      e_adv = 1; e_done = 1;
    end else if (cmd_ready) begin
      if (cmd == DRO_CMD_CONFIG_TX)  e_adv = 1;
      else if (cmd == DRO_CMD_SEND)  e_adv = !m_slot_v || !m_act;
      else                           e_done = 1;
    end
    chk("dro_clk", dro_clk, e_clk);
    chk("dro_do", dro_do, e_do);
    chk("busy", busy, m_act || m_slot_v);
    chk("arg_advance", arg_advance, e_adv);
    chk("cmd_done", cmd_done, e_done);
    chk("pend_valid", debug[8], m_slot_v);
  endtask

  task automatic model_step();
    bit free, drain;
    int n;
    free  = !m_slot_v || !m_act;
    drain = m_slot_v && !m_act;
    if (m_act && (cyc + 1 - m_s) == 2 * m_h * m_n + m_g) m_act = 0;
    if (drain) begin
      m_act = 1; m_s = cyc + 1; m_val = m_slot_val; m_n = m_slot_n;
      m_h = m_half; m_g = m_gap; m_slot_v = 0;
    end
    if (m_phase == 0) begin
      if (cmd_ready) begin
        if (cmd == DRO_CMD_CONFIG_TX) begin
          m_half = tval(arg_data); m_cfg = 1; m_phase = 1;
        end else if (cmd == DRO_CMD_SEND && free) begin
          m_arg0 = arg_data; m_cfg = 0; m_phase = 1;
        end
      end
    end else begin
      m_phase = 0;
      if (m_cfg) m_gap = tval(arg_data);
      else begin
        n = int'(arg_data[5:0]);
        if (n > 32) n = 32;
        if (n != 0) begin
          m_slot_v = 1; m_slot_val = m_arg0; m_slot_n = n;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) model_reset();
      model_check();
      if (rst_n) model_step();
    end
  end

  // ---------------- behavioural DRO receiver ----------------
  int          rx_timeout = 50;
  int          rx_cyc = 0;
  logic [31:0] rx_vals[$];
  int          rx_bits[$];
  int          rx_rise[$];

  initial begin
    logic prev;
    logic [31:0] acc;
    int nb, hi;
    prev = 1; acc = 0; nb = 0; hi = 0;
    forever begin
      @(negedge clk);
      rx_cyc++;
      if (!rst_n) begin
        prev = 1; acc = 0; nb = 0; hi = 0;
      end else begin
        if (!prev && dro_clk) begin
          acc = {acc[30:0], dro_do};
          nb++;
          rx_rise.push_back(rx_cyc);
        end
        if (dro_clk && nb > 0) begin
          hi++;
          if (hi >= rx_timeout) begin
            rx_vals.push_back(acc); rx_bits.push_back(nb);
            acc = 0; nb = 0; hi = 0;
          end
        end else hi = 0;
        prev = dro_clk;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_rx();
    rx_vals.delete(); rx_bits.delete(); rx_rise.delete();
  endtask

  task automatic do_cmd(input logic [7:0] c, input logic [31:0] a0, input logic [31:0] a1,
                        output int cycles);
    logic adv, done;
    done = 0;
    @(posedge clk); #1;
    cmd = c; arg_data = a0; cmd_ready = 1; cycles = 0;
    while (cycles < 5000) begin
      @(negedge clk);
      adv = arg_advance; done = cmd_done;
      cycles++;
      @(posedge clk); #1;
      if (done) break;
      if (adv) arg_data = a1;
    end
    cmd_ready = 0;
    chk("cmd_handshake", done, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("idle_wait", busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_frame(input string name, input int idx, input logic [31:0] v, input int nb);
    chk({name, "_present"}, rx_vals.size() > idx, 1'b1);
    if (rx_vals.size() > idx) begin
      chk({name, "_value"}, rx_vals[idx], v);
      chk({name, "_bits"}, rx_bits[idx], nb);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c, n, c3;
    logic [7:0] u;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_dro_clk", dro_clk, 1'b1);
    chk("rst_dro_do", dro_do, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_debug", debug, 16'h0000);

    // 0xA5 over 8 bits with half=4, gap=100
    clear_rx(); rx_timeout = 50;
    do_cmd(DRO_CMD_CONFIG_TX, 4, 100, c);
    chk("cfg_cycles", c, 2);
    do_cmd(DRO_CMD_SEND, 32'hA5, 8, c);
    chk("send_cycles", c, 2);
    wait_idle();
    chk_frame("a5", 0, 32'hA5, 8);
    chk("a5_rises", rx_rise.size(), 8);
    for (int i = 1; i < rx_rise.size(); i++) chk("a5_spacing", rx_rise[i] - rx_rise[i-1], 8);

    // zero-length SEND is discarded
    clear_rx();
    do_cmd(DRO_CMD_SEND, 32'h3, 0, c);
    chk("zero_cycles", c, 2);
    repeat (10) @(negedge clk);
    chk("zero_busy", busy, 1'b0);
    chk("zero_rises", rx_rise.size(), 0);

    // nbits 40 clamps to 32
    clear_rx(); rx_timeout = 10;
    do_cmd(DRO_CMD_CONFIG_TX, 2, 30, c);
    do_cmd(DRO_CMD_SEND, 32'hFFFF_FFFF, 40, c);
    wait_idle();
    chk_frame("clamp", 0, 32'hFFFF_FFFF, 32);
    chk("clamp_rises", rx_rise.size(), 32);

    // three back-to-back SENDs; the third must stall on the full slot
    clear_rx();
    do_cmd(DRO_CMD_CONFIG_TX, 3, 20, c);
    do_cmd(DRO_CMD_SEND, 32'h1, 4, c);
    do_cmd(DRO_CMD_SEND, 32'h2, 4, c);
    do_cmd(DRO_CMD_SEND, 32'h3, 4, c3);
    chk("third_stalled", c3 > 20, 1'b1);
    wait_idle();
    chk_frame("b2b0", 0, 32'h1, 4);
    chk_frame("b2b1", 1, 32'h2, 4);
    chk_frame("b2b2", 2, 32'h3, 4);

    // loopback-style frame
    clear_rx(); rx_timeout = 50;
    do_cmd(DRO_CMD_CONFIG_TX, 10, 200, c);
    do_cmd(DRO_CMD_SEND, 32'h12345, 20, c);
    wait_idle();
    chk_frame("loop", 0, 32'h12345, 20);

    // randomized traffic, checked cycle by cycle by the model
    rx_timeout = 1_000_000;
    for (int it = 0; it < 60; it++) begin
      n = $urandom_range(0, 9);
      if (n < 2) do_cmd(DRO_CMD_CONFIG_TX, $urandom_range(0, 4), $urandom_range(0, 30), c);
      else if (n == 2) begin
        do u = 8'($urandom); while (u == DRO_CMD_CONFIG_TX || u == DRO_CMD_SEND);
        do_cmd(u, $urandom, $urandom, c);
        chk("unknown_cycles", c, 1);
      end else do_cmd(DRO_CMD_SEND, $urandom, $urandom_range(0, 40), c);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    wait_idle();

    // reset in the low phase of bit 3 of 0xB5 (bits 1,0,1,1,...)
    rx_timeout = 50;
    do_cmd(DRO_CMD_CONFIG_TX, 4, 100, c);
    clear_rx();
    do_cmd(DRO_CMD_SEND, 32'hB5, 8, c);
    n = 0;
    while (rx_rise.size() < 3 && n < 2000) begin @(negedge clk); n++; end
    chk("rst_reach_bit3", rx_rise.size() >= 3, 1'b1);
    n = 0;
    while (dro_clk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    chk("pre_rst_clk", dro_clk, 1'b0);
    chk("pre_rst_do", dro_do, 1'b1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_clk", dro_clk, 1'b1);
    chk("async_rst_do", dro_do, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_debug", debug, 16'h0000);
    clear_rx();
    repeat (20) @(negedge clk);
    chk("post_rst_rises", rx_rise.size(), 0);

    // default timing restored by reset
    do_cmd(DRO_CMD_SEND, 32'h1, 1, c);
    n = 0;
    while (dro_clk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (dro_clk === 1'b0 && n < 100) begin n++; @(negedge clk); end
    chk("def_half_low", n, DEF_H);
    wait_idle();
    chk_frame("def", 0, 32'h1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
